// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and constants for the instruction fetch front end
package cpu_fetch_pkg;

    localparam int          FETCH_DWIDTH     = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]             pc;
        logic [FETCH_DWIDTH-1:0] inst;
        logic                    misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - memory read port and decode handshake bundle of the fetch unit
interface inst_fetch_unit_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
);
    logic [AWIDTH-1:0] fetch_addr;
    logic [DWIDTH-1:0] imem_inst;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [DWIDTH-1:0] out_inst;
    logic              out_misaligned;

    modport master (
        output fetch_addr,
        input  imem_inst,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        output out_misaligned
    );

    modport slave (
        input  fetch_addr,
        output imem_inst,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        input  out_misaligned
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular prefetch FIFO with flush and same-cycle push/pop
module fetch_fifo
    import cpu_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            pop_ok;

    assign empty  = (level == '0);
    assign pop_ok = pop & ~empty;
    assign rdata  = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(push) - LW'(pop_ok);
        end
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC sequencing, redirect/halt control and prefetch for instruction fetch
module inst_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int          AWIDTH   = 12,
    parameter int          DWIDTH   = FETCH_DWIDTH,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       fetch_halt,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    inst_fetch_unit_if.master          bus
);
    localparam int LW = $clog2(DEPTH+1);

    logic [31:0]  pc;
    logic         mis_pending;
    logic         push;
    logic         pop;
    logic         empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    assign bus.fetch_addr = pc[AWIDTH+1:2];

    assign pop  = bus.out_valid & bus.out_ready;
    // A full FIFO still accepts a fetch when the head leaves in the same cycle
    assign push = ~redirect_valid & ~fetch_halt & ((fifo_level < LW'(DEPTH)) | pop);

    assign wr_entry.pc         = pc;
    assign wr_entry.inst       = bus.imem_inst;
    assign wr_entry.misaligned = mis_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            mis_pending <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            mis_pending <= |redirect_pc[1:0];
        end else if (push) begin
            pc          <= pc + PC_STEP;
            mis_pending <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .empty (empty),
        .level (fifo_level)
    );

    assign bus.out_valid      = ~empty;
    assign bus.out_pc         = head.pc;
    assign bus.out_inst       = head.inst;
    assign bus.out_misaligned = head.misaligned;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit with a queue-based reference model
module tb_inst_fetch_unit;

    localparam int MDEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_halt;
    logic        ready;
    logic [1:0]  fifo_level;
    logic [31:0] mem [4096];

    int total = 0;
    int bad   = 0;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_mis;

    always #5 clk = ~clk;

    inst_fetch_unit_if #(.AWIDTH(12), .DWIDTH(32)) bus ();

    assign bus.imem_inst = mem[bus.fetch_addr];
    assign bus.out_ready = ready;

    inst_fetch_unit #(
        .AWIDTH   (12),
        .DWIDTH   (32),
        .DEPTH    (MDEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_halt     (fetch_halt),
        .fifo_level     (fifo_level),
        .bus            (bus.master)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] byte_pc);
        return 32'h1000_0000 + ((byte_pc >> 2) & 32'h0000_0FFF);
    endfunction

    // Advance the model from the inputs seen before the edge, then compare after it
    task automatic step();
        bit   pop_m;
        bit   push_m;
        ent_t e;
        if (rst) begin
            q.delete();
            m_pc  = 32'h0;
            m_mis = 1'b0;
        end else if (redirect_valid) begin
            q.delete();
            m_pc  = redirect_pc & 32'hFFFF_FFFC;
            m_mis = |redirect_pc[1:0];
        end else begin
            pop_m  = (q.size() != 0) && ready;
            push_m = !fetch_halt && ((q.size() < MDEPTH) || pop_m);
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                e.pc   = m_pc;
                e.inst = mem_word(m_pc);
                e.mis  = m_mis;
                q.push_back(e);
                m_pc  = m_pc + 32'd4;
                m_mis = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("model_level", 64'(fifo_level), 64'(q.size()));
        check("model_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        check("model_addr", 64'(bus.fetch_addr), 64'(m_pc[13:2]));
        if (q.size() != 0) begin
            check("model_pc", 64'(bus.out_pc), 64'(q[0].pc));
            check("model_inst", 64'(bus.out_inst), 64'(q[0].inst));
            check("model_mis", 64'(bus.out_misaligned), 64'(q[0].mis));
        end
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = 32'h1000_0000 + k;
        rst = 1'b1; ready = 1'b0; fetch_halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        step();
        step();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_pc", 64'(bus.out_pc), 64'd0);
        check("rst_inst", 64'(bus.out_inst), 64'd0);
        check("rst_mis", 64'(bus.out_misaligned), 64'd0);
        check("rst_addr", 64'(bus.fetch_addr), 64'd0);

        rst = 1'b0; ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stream_valid", 64'(bus.out_valid), 64'd1);
            check("stream_pc", 64'(bus.out_pc), 64'(k * 4));
            check("stream_inst", 64'(bus.out_inst), 64'(32'h1000_0000 + k));
        end

        rst = 1'b1; step();
        rst = 1'b0; ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("stall_level", 64'(fifo_level), 64'd2);
        check("stall_addr", 64'(bus.fetch_addr), 64'd2);
        check("stall_pc", 64'(bus.out_pc), 64'd0);
        check("stall_inst", 64'(bus.out_inst), 64'h1000_0000);
        ready = 1'b1; step();
        check("release_pc", 64'(bus.out_pc), 64'h4);
        step();
        check("release_pc2", 64'(bus.out_pc), 64'h8);

        ready = 1'b0; step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h50; step();
        check("redir_level", 64'(fifo_level), 64'd0);
        check("redir_addr", 64'(bus.fetch_addr), 64'd20);
        check("redir_valid", 64'(bus.out_valid), 64'd0);
        redirect_valid = 1'b0; step();
        check("redir_hvalid", 64'(bus.out_valid), 64'd1);
        check("redir_hpc", 64'(bus.out_pc), 64'h50);
        check("redir_hinst", 64'(bus.out_inst), 64'h1000_0014);
        check("redir_hmis", 64'(bus.out_misaligned), 64'd0);

        redirect_valid = 1'b1; redirect_pc = 32'h52; step();
        redirect_valid = 1'b0; step();
        check("mis_pc", 64'(bus.out_pc), 64'h50);
        check("mis_flag", 64'(bus.out_misaligned), 64'd1);
        step();
        ready = 1'b1; step();
        check("mis_next_pc", 64'(bus.out_pc), 64'h54);
        check("mis_next_flag", 64'(bus.out_misaligned), 64'd0);

        fetch_halt = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("halt_valid", 64'(bus.out_valid), 64'd0);
        check("halt_level", 64'(fifo_level), 64'd0);
        check("halt_addr", 64'(bus.fetch_addr), 64'd23);
        fetch_halt = 1'b0; step();
        check("resume_pc", 64'(bus.out_pc), 64'h5C);
        step();
        check("resume_pc2", 64'(bus.out_pc), 64'h60);

        redirect_valid = 1'b1; redirect_pc = 32'h0000_3FFC; step();
        check("wrap_addr0", 64'(bus.fetch_addr), 64'd4095);
        redirect_valid = 1'b0; step();
        check("wrap_addr1", 64'(bus.fetch_addr), 64'd0);
        check("wrap_pc0", 64'(bus.out_pc), 64'h3FFC);
        check("wrap_inst0", 64'(bus.out_inst), 64'h1000_0FFF);
        step();
        check("wrap_pc1", 64'(bus.out_pc), 64'h4000);
        check("wrap_inst1", 64'(bus.out_inst), 64'h1000_0000);

        ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100; step();
        redirect_pc = 32'h206; step();
        redirect_valid = 1'b0; step();
        check("b2b_level", 64'(fifo_level), 64'd1);
        check("b2b_pc", 64'(bus.out_pc), 64'h204);
        check("b2b_mis", 64'(bus.out_misaligned), 64'd1);

        step();
        rst = 1'b1; step();
        check("midrst_level", 64'(fifo_level), 64'd0);
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_addr", 64'(bus.fetch_addr), 64'd0);
        rst = 1'b0;

        for (int n = 0; n < 600; n++) begin
            ready          = ($urandom_range(0, 3) != 0);
            fetch_halt     = ($urandom_range(0, 7) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            rst            = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
